output_buffer_drain: RTL and testbench
======================================

# output_buffer_drain

Read side of the 16-entry output buffer that the accumulator writes finished results into through its `output_data` / `output_buffer_addr` / `output_buffer_enable` write port. The block holds the buffer storage and a per-entry valid bit. On a drain command it streams a contiguous, wrapping range of entries to the host over a valid/ready interface. It stalls on entries the accumulator has not yet written, and frees each entry when the host accepts it.

## Interface
- `DEPTH`, 16, number of buffer entries (power of two)
- `ADDR_W`, 4, entry address width, log2(DEPTH)
- `DATA_W`, 32, entry width (bfp32 word)

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe from the accumulator's `output_buffer_enable`
- `wr_addr`  in  ADDR_W  write address from the accumulator's `output_buffer_addr`
- `wr_data`  in  DATA_W  write data from the accumulator's `output_data`
- `drain_start`  in  1  single-cycle drain command; sampled only in IDLE
- `drain_base`  in  ADDR_W  first entry to drain
- `drain_count`  in  ADDR_W+1  number of entries to drain, 0..DEPTH
- `drain_busy`  out  1  high in any state other than IDLE
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  host accepts the beat
- `out_data`  out  DATA_W  beat payload
- `out_addr`  out  ADDR_W  buffer address of the beat
- `out_last`  out  1  high on the final beat of a drain
- `drain_done`  out  1  one-cycle pulse after the final handshake
- `overwrite_err`  out  1  one-cycle pulse when a write lands on a still-valid entry

## Operation
- **Storage:** DEPTH x DATA_W registers plus `vld[DEPTH-1:0]`.
  - `wr_en` writes `wr_data` to `wr_addr` and sets `vld[wr_addr]`. Writes are accepted in every state.
- **FSM states:** IDLE, FETCH, SEND, DONE.
- **IDLE:**
  - `drain_start` with `drain_count` != 0: latch `ptr` = `drain_base` and `rem` = `drain_count`, then go to FETCH.
  - `drain_start` with `drain_count` == 0: go to DONE and emit no beats.
- **FETCH:** when `vld[ptr]` = 1:
  - load `out_data` = mem[ptr], `out_addr` = `ptr`, `out_last` = (`rem` == 1);
  - set `out_valid`, clear `vld[ptr]`, go to SEND.
  - Otherwise stay in FETCH.
- **SEND:** on `out_valid` && `out_ready`, decrement `rem` and set `ptr` = `ptr`+1 mod DEPTH (wraps 15 to 0). Then:
  - if that was the last beat: drop `out_valid` and `out_last`, go to DONE;
  - else if `vld[next ptr]` = 1: load the next beat in the same edge (back-to-back), stay in SEND;
  - else: drop `out_valid`, go to FETCH.
- **DONE:** `drain_done` = 1 for one cycle, then go to IDLE.
- **Beat stability:** while `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_addr` and `out_last` hold stable.
- **Write and clear on the same entry in the same cycle:** the set wins. `vld` stays 1, the in-flight beat carries the old data, and `overwrite_err` is not raised.
- **`overwrite_err`:** pulses when `wr_en` targets an entry with `vld` = 1 that is not being cleared that cycle. The data is overwritten and `vld` stays 1.
- **`drain_start` outside IDLE:** ignored.

## Timing
- **Reset values:**
  - `vld` = 0, FSM in IDLE;
  - `drain_busy`, `out_valid`, `out_last`, `drain_done`, `overwrite_err` = 0;
  - `out_data` = 0, `out_addr` = 0;
  - storage contents are not reset.
- **Reset mid-drain:** the stream aborts immediately (`out_valid` = 0) and all entries are invalidated.
- **Latency from start:** `drain_start` sampled at edge E puts the FSM in FETCH after E. If the entry is valid, `out_valid` is high after edge E+1. `drain_busy` is high after edge E.
- **Latency from write:** a write at edge W to the pending `ptr` (while in FETCH) gives `out_valid` after edge W+1.
- **Throughput:** one beat per cycle while the next entry is already valid. Each stall on an unwritten entry adds at least one bubble cycle.
- **End of drain:** the final handshake at edge H gives `drain_done` high during H+1..H+2 (one cycle). The FSM is back in IDLE after edge H+2.
- **All outputs are registered.**

## Test plan
- **Back-to-back drain:**
  - write entries 0..3 with 0x3F800000, 0x40000000, 0x40400000, 0x40800000;
  - drain base 0, count 4, `out_ready` held 1;
  - expect 4 consecutive beats with `out_addr` 0..3 and matching data;
  - expect `out_last` on beat 3, `drain_done` one cycle later, `vld` all 0.
- **Wrap-around:** write entries 14, 15, 0; drain base 14, count 3 -> `out_addr` sequence 14, 15, 0 with correct data.
- **Stall on unwritten entry:**
  - drain base 5, count 2 with only entry 5 written -> beat 5, then `out_valid` low;
  - write entry 6 = 0xC0000000 at edge W -> beat 6 valid after W+1 with `out_last` = 1.
- **Backpressure:**
  - hold `out_ready` = 0 for 5 cycles mid-drain -> `out_data`, `out_addr`, `out_last` unchanged;
  - no beat lost or duplicated.
- **Edge cases:**
  - `drain_count` = 0 -> no `out_valid`, `drain_done` pulse;
  - `drain_start` while busy -> ignored;
  - write to valid entry 7 -> `overwrite_err` pulse and new data read back;
  - write entry 8 on the same edge that it is dequeued -> `vld[8]` remains 1, no error.
- **Reset mid-drain:**
  - assert `rst` low asynchronously during SEND -> `out_valid` = 0 and `drain_busy` = 0 immediately;
  - after release, `vld` = 0 and a new drain stalls in FETCH.

Source files
------------

// File: rtl/output_buffer_drain.sv
// Read side of the accumulator output buffer: entry storage with per-entry valid bits,
// drained to the host as a contiguous wrapping range over a valid/ready stream.
module output_buffer_drain #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_base,
   input  logic [ADDR_W:0]   drain_count,
   output logic              drain_busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              drain_done,
   output logic              overwrite_err
);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

   localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] REM_TWO = (ADDR_W+1)'(2);

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_nxt;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W:0]   rem;
   logic              hs;
   logic              last_hs;
   logic              load_en;
   logic [DEPTH-1:0]  set_mask;
   logic [DEPTH-1:0]  clr_mask;

   // load_en/load_addr name the entry moved into the output register this edge;
   // that entry's valid bit is cleared unless a write to it lands on the same edge.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      ptr_nxt   = ptr + 1'b1;
      hs        = (state == SEND) && out_valid && out_ready;
      last_hs   = hs && (rem == REM_ONE);
      load_en   = 1'b0;
      load_addr = ptr;
      set_mask  = '0;
      clr_mask  = '0;
      case (state)
         FETCH: load_en = vld[ptr];
         SEND: begin
            load_addr = ptr_nxt;
            load_en   = hs && !last_hs && vld[ptr_nxt];
         end
         default: ;
      endcase
      if (wr_en)   set_mask[wr_addr]   = 1'b1;
      if (load_en) clr_mask[load_addr] = 1'b1;
   end

   // NOTE: storage has no reset; only the valid bits say whether an entry holds data.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld           <= '0;
         overwrite_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         vld           <= (vld & ~clr_mask) | set_mask;
         overwrite_err <= wr_en && vld[wr_addr] && !clr_mask[wr_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ptr        <= '0;
         rem        <= '0;
         drain_busy <= 1'b0;
         drain_done <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_addr   <= '0;
         out_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (drain_start) begin
                  ptr        <= drain_base;
                  rem        <= drain_count;
                  drain_busy <= 1'b1;
                  state      <= (drain_count != '0) ? FETCH : DONE;
               end
            end
            FETCH: begin
               if (load_en) begin
                  out_valid <= 1'b1;
                  out_data  <= mem[ptr];
                  out_addr  <= ptr;
                  out_last  <= (rem == REM_ONE);
                  state     <= SEND;
               end
            end
            SEND: begin
               if (hs) begin
                  rem <= rem - 1'b1;
                  ptr <= ptr_nxt;
                  if (last_hs) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= DONE;
                  end else if (load_en) begin
                     out_data <= mem[ptr_nxt];
                     out_addr <= ptr_nxt;
                     out_last <= (rem == REM_TWO);
                  end else begin
                     out_valid <= 1'b0;
                     state     <= FETCH;
                  end
               end
            end
            DONE: begin
               // One cycle to raise the pulse, one to drop it and release busy.
               if (!drain_done) begin
                  drain_done <= 1'b1;
               end else begin
                  drain_done <= 1'b0;
                  drain_busy <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_buffer_drain.sv
// Self-checking bench for output_buffer_drain: cycle vector table, directed corner
// sequences, and randomized drains checked against a queue-free buffer model.
module tb_output_buffer_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        drain_start;
   logic [3:0]  drain_base;
   logic [4:0]  drain_count;
   logic        drain_busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_addr;
   logic        out_last;
   logic        drain_done;
   logic        overwrite_err;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem_m [16];
   bit          vld_m [16];

   typedef struct {
      logic        wr;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        st;
      logic [3:0]  base;
      logic [4:0]  cnt;
      logic        rdy;
      logic        e_valid;
      logic [3:0]  e_addr;
      logic [31:0] e_data;
      logic        e_last;
      logic        e_done;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   output_buffer_drain #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .drain_start(drain_start), .drain_base(drain_base), .drain_count(drain_count),
      .drain_busy(drain_busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last),
      .drain_done(drain_done), .overwrite_err(overwrite_err)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic void add(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                               input logic st, input logic [3:0] base, input logic [4:0] cnt,
                               input logic rdy, input logic ev, input logic [3:0] ea,
                               input logic [31:0] ed, input logic el, input logic edn,
                               input logic eb, input logic ee);
      vec_t v;
      v.wr = wr; v.wa = wa; v.wd = wd; v.st = st; v.base = base; v.cnt = cnt; v.rdy = rdy;
      v.e_valid = ev; v.e_addr = ea; v.e_data = ed; v.e_last = el;
      v.e_done = edn; v.e_busy = eb; v.e_err = ee;
      vq.push_back(v);
   endfunction

   task automatic clear_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      drain_start = 1'b0; drain_base = '0; drain_count = '0;
      out_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      cyc();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) vld_m[i] = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d);
      bit exp_err;
      exp_err = vld_m[a];
      wr(a, d);
      check("write_err", 32'(overwrite_err), 32'(exp_err));
      mem_m[a] = d;
      vld_m[a] = 1'b1;
   endtask

   task automatic start(input logic [3:0] base, input logic [4:0] cnt);
      drain_start = 1'b1; drain_base = base; drain_count = cnt;
      cyc();
      drain_start = 1'b0;
      check("start_busy", 32'(drain_busy), 32'd1);
   endtask

   task automatic wait_valid(input string name, input int max);
      int n = 0;
      while (!out_valid && n < max) begin
         cyc();
         n++;
      end
      check(name, 32'(out_valid), 32'd1);
   endtask

   // Called at the sample point right after the final handshake edge.
   task automatic finish_drain(input string name);
      check({name, "_end_valid"}, 32'(out_valid), 32'd0);
      check({name, "_end_done0"}, 32'(drain_done), 32'd0);
      cyc();
      check({name, "_done"}, 32'(drain_done), 32'd1);
      check({name, "_done_busy"}, 32'(drain_busy), 32'd1);
      cyc();
      check({name, "_done_clr"}, 32'(drain_done), 32'd0);
      check({name, "_idle"}, 32'(drain_busy), 32'd0);
   endtask

   // Expected beat i of a drain is entry (base+i) mod 16 holding its last written value.
   task automatic drain_check(input logic [3:0] base, input int count, input bit rnd);
      int idx = 0;
      int n = 0;
      logic [3:0] ea;
      logic [3:0] wa;
      start(base, 5'(count));
      while (idx < count && n < 3000) begin
         check("drain_err", 32'(overwrite_err), 32'd0);
         if (out_valid) begin
            ea = base + 4'(idx);
            check("beat_addr", 32'(out_addr), 32'(ea));
            check("beat_data", out_data, mem_m[ea]);
            check("beat_last", 32'(out_last), 32'(idx == count - 1));
            out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            if (out_ready) begin
               idx++;
               vld_m[ea] = 1'b0;
            end
         end else begin
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
         end
         if (rnd && $urandom_range(1) == 1) begin
            wa = ($urandom_range(1) == 1) ? base + 4'(idx) : 4'($urandom_range(15));
            if (!vld_m[wa]) begin
               wr_en = 1'b1; wr_addr = wa; wr_data = $urandom;
               mem_m[wa] = wr_data;
               vld_m[wa] = 1'b1;
            end
         end
         cyc();
         wr_en = 1'b0;
         n++;
      end
      check("drain_beats", 32'(idx), 32'(count));
      out_ready = 1'b1;
      if (idx == count) finish_drain("drain");
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      for (int i = 0; i < 16; i++) vld_m[i] = 1'b0;
      cyc();
      cyc();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(drain_busy), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_done", 32'(drain_done), 32'd0);
      check("rst_err", 32'(overwrite_err), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_addr", 32'(out_addr), 32'd0);
      rst = 1'b1;
      cyc();

      // Back-to-back drain, ignored start, overwrite, count 0, stall-until-written.
      //  wr wa     wd            st base   cnt    rdy ev ea     edata         el dn bs er
      add(1, 4'd0, 32'h3F800000, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(1, 4'd1, 32'h40000000, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(1, 4'd2, 32'h40400000, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(1, 4'd3, 32'h40800000, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(0, 4'd0, 32'h0,        1, 4'd0, 5'd4,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  1, 4'd0,  32'h3F800000, 0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        1, 4'd9, 5'd0,  1,  1, 4'd1,  32'h40000000, 0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  1, 4'd2,  32'h40400000, 0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  1, 4'd3,  32'h40800000, 1, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 1, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(1, 4'd7, 32'h11111111, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(1, 4'd7, 32'h22222222, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 1);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(0, 4'd0, 32'h0,        1, 4'd7, 5'd1,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  1, 4'd7,  32'h22222222, 1, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 1, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(0, 4'd0, 32'h0,        1, 4'd3, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 1, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);
      add(0, 4'd0, 32'h0,        1, 4'd0, 5'd4,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(1, 4'd0, 32'h3F800001, 0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(1, 4'd1, 32'h40000001, 0, 4'd0, 5'd0,  1,  1, 4'd0,  32'h3F800001, 0, 0, 1, 0);
      add(1, 4'd2, 32'h40400001, 0, 4'd0, 5'd0,  1,  1, 4'd1,  32'h40000001, 0, 0, 1, 0);
      add(1, 4'd3, 32'h40800001, 0, 4'd0, 5'd0,  1,  1, 4'd2,  32'h40400001, 0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  1, 4'd3,  32'h40800001, 1, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 1, 1, 0);
      add(0, 4'd0, 32'h0,        0, 4'd0, 5'd0,  1,  0, 4'd0,  32'h0,        0, 0, 0, 0);

      foreach (vq[i]) begin
         wr_en = vq[i].wr; wr_addr = vq[i].wa; wr_data = vq[i].wd;
         drain_start = vq[i].st; drain_base = vq[i].base; drain_count = vq[i].cnt;
         out_ready = vq[i].rdy;
         cyc();
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vq[i].e_valid));
         check($sformatf("vec%0d_last", i), 32'(out_last), 32'(vq[i].e_last));
         check($sformatf("vec%0d_done", i), 32'(drain_done), 32'(vq[i].e_done));
         check($sformatf("vec%0d_busy", i), 32'(drain_busy), 32'(vq[i].e_busy));
         check($sformatf("vec%0d_err", i), 32'(overwrite_err), 32'(vq[i].e_err));
         if (vq[i].e_valid) begin
            check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(vq[i].e_addr));
            check($sformatf("vec%0d_data", i), out_data, vq[i].e_data);
         end
      end
      clear_inputs();

      // Wrap-around 14, 15, 0.
      do_write(4'd14, 32'h41000000);
      do_write(4'd15, 32'h41100000);
      do_write(4'd0, 32'h41200000);
      drain_check(4'd14, 3, 1'b0);

      // Stall on unwritten entry 6, then write it.
      wr(4'd5, 32'h40A00000);
      start(4'd5, 5'd2);
      wait_valid("stall_first", 5);
      check("stall_addr5", 32'(out_addr), 32'd5);
      check("stall_data5", out_data, 32'h40A00000);
      cyc();
      check("stall_gap0", 32'(out_valid), 32'd0);
      cyc();
      check("stall_gap1", 32'(out_valid), 32'd0);
      wr(4'd6, 32'hC0000000);
      check("stall_at_w", 32'(out_valid), 32'd0);
      cyc();
      check("stall_w1_valid", 32'(out_valid), 32'd1);
      check("stall_w1_addr", 32'(out_addr), 32'd6);
      check("stall_w1_data", out_data, 32'hC0000000);
      check("stall_w1_last", 32'(out_last), 32'd1);
      cyc();
      finish_drain("stall");

      // Backpressure: five cycles of out_ready low must hold the beat.
      wr(4'd12, 32'h12121212);
      wr(4'd13, 32'h13131313);
      out_ready = 1'b0;
      start(4'd12, 5'd2);
      wait_valid("bp_first", 5);
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_addr", 32'(out_addr), 32'd12);
         check("bp_hold_data", out_data, 32'h12121212);
         check("bp_hold_last", 32'(out_last), 32'd0);
         cyc();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      cyc();
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_addr", 32'(out_addr), 32'd13);
      check("bp_next_data", out_data, 32'h13131313);
      check("bp_next_last", 32'(out_last), 32'd1);
      cyc();
      finish_drain("bp");

      // Write entry 8 on the edge it is dequeued: old data out, valid kept, no error.
      wr(4'd8, 32'h88880001);
      out_ready = 1'b0;
      start(4'd8, 5'd1);
      wr(4'd8, 32'h88880002);
      check("same_valid", 32'(out_valid), 32'd1);
      check("same_data", out_data, 32'h88880001);
      check("same_err", 32'(overwrite_err), 32'd0);
      out_ready = 1'b1;
      cyc();
      finish_drain("same");
      start(4'd8, 5'd1);
      cyc();
      check("same_kept_valid", 32'(out_valid), 32'd1);
      check("same_kept_data", out_data, 32'h88880002);
      cyc();
      finish_drain("same2");

      // Asynchronous reset in SEND.
      wr(4'd10, 32'hAAAA0000);
      wr(4'd11, 32'hBBBB0000);
      out_ready = 1'b0;
      start(4'd10, 5'd2);
      wait_valid("rstm_first", 5);
      #2 rst = 1'b0;
      #1;
      check("rstm_valid", 32'(out_valid), 32'd0);
      check("rstm_busy", 32'(drain_busy), 32'd0);
      cyc();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) vld_m[i] = 1'b0;
      out_ready = 1'b1;
      start(4'd10, 5'd1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("rstm_stall_valid", 32'(out_valid), 32'd0);
         check("rstm_stall_busy", 32'(drain_busy), 32'd1);
      end
      do_reset();

      // Randomized drains with random writes and random backpressure.
      for (int t = 0; t < 20; t++) begin
         int pre;
         pre = $urandom_range(4);
         for (int k = 0; k < pre; k++) do_write(4'($urandom_range(15)), $urandom);
         drain_check(4'($urandom_range(15)), $urandom_range(16, 1), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
